// File: rtl/fb_uart_readback.sv
// Frame-buffer readback transmitter: streams HDR, a RAM byte range and its
// 8-bit checksum out of uart_tx as back-to-back 8N1 frames.
module fb_uart_readback #(
  parameter int unsigned BAUD_DIV = 208,
  parameter int unsigned ADDR_W   = 20,
  parameter logic [7:0]  HDR      = 8'hA5
) (
  input  logic              clk_o0,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              uart_tx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [3:0]  BIT_START = 4'd0;
  localparam logic [3:0]  BIT_D0    = 4'd1;
  localparam logic [3:0]  BIT_STOP  = 4'd9;

  state_t            state;
  state_t            state_nxt;

  logic [11:0]       baud_cnt;
  logic [3:0]        bit_idx;
  logic [7:0]        shreg;
  logic [7:0]        pref_buf;
  logic [7:0]        sum;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] remaining;
  logic              rd_pend;
  logic              csum_sent;

  logic              accept;
  logic              baud_wrap;
  logic              frame_end;
  logic              rd_fire;

  always_comb begin
    accept    = (state == ST_IDLE) && start;
    baud_wrap = (baud_cnt == BAUD_LAST);
    frame_end = (state == ST_SHIFT) && baud_wrap && (bit_idx == BIT_STOP);
    // Prefetch the next payload byte at the first cycle of d0 of every frame
    // while bytes remain; the frame's remaining 8+ bit times hide the latency.
    rd_fire   = (state == ST_SHIFT) && (bit_idx == BIT_D0) &&
                (baud_cnt == '0) && (remaining != '0);
  end

  always_ff @(posedge clk_o0 or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (frame_end && (remaining == '0) && csum_sent) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == ST_SHIFT);
    done    = (state == ST_DONE);
    rd_en   = rd_fire;
    rd_addr = addr;
    uart_tx = 1'b1;
    if (state == ST_SHIFT) begin
      if (bit_idx == BIT_START) begin
        uart_tx = 1'b0;
      end else if (bit_idx == BIT_STOP) begin
        uart_tx = 1'b1;
      end else begin
        uart_tx = shreg[0];
      end
    end
  end

  always_ff @(posedge clk_o0 or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      pref_buf  <= '0;
      sum       <= '0;
      addr      <= '0;
      remaining <= '0;
      rd_pend   <= 1'b0;
      csum_sent <= 1'b0;
    end else begin
      rd_pend <= rd_fire;
      if (rd_fire) begin
        addr <= addr + ADDR_W'(1);
      end
      if (rd_pend) begin
        pref_buf <= rd_data;
        sum      <= sum + rd_data;
      end

      if (accept) begin
        addr      <= start_addr;
        remaining <= len;
        sum       <= '0;
        shreg     <= HDR;
        csum_sent <= 1'b0;
        baud_cnt  <= '0;
        bit_idx   <= '0;
      end else if (state == ST_SHIFT) begin
        if (baud_wrap) begin
          baud_cnt <= '0;
          if (bit_idx == BIT_STOP) begin
            bit_idx <= '0;
            if (remaining != '0) begin
              shreg     <= pref_buf;
              remaining <= remaining - ADDR_W'(1);
            end else if (!csum_sent) begin
              shreg     <= sum;
              csum_sent <= 1'b1;
            end
          end else begin
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx != BIT_START) begin
              shreg <= {1'b0, shreg[7:1]};
            end
          end
        end else begin
          baud_cnt <= baud_cnt + 12'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_uart_readback.sv
// Scoreboard bench for fb_uart_readback: two instances (BAUD_DIV 8 and default),
// RAM model per instance, UART receiver monitor popping expected frames.
module tb_fb_uart_readback;

  typedef struct {
    logic [7:0] data;
    int         at;
  } frame_t;

  logic        clk;
  logic        rst_n      [2];
  logic        start      [2];
  logic [19:0] start_addr [2];
  logic [19:0] len        [2];
  logic        rd_en      [2];
  logic [19:0] rd_addr    [2];
  logic [7:0]  rd_data    [2];
  logic        uart_tx    [2];
  logic        busy       [2];
  logic        done       [2];

  int checks = 0;
  int errors = 0;
  int tick   = 0;

  frame_t q0[$];
  frame_t q1[$];
  logic [7:0] ram [logic [20:0]];

  fb_uart_readback #(.BAUD_DIV(8)) dut0 (
    .clk_o0(clk), .reset_n(rst_n[0]), .start(start[0]),
    .start_addr(start_addr[0]), .len(len[0]), .rd_en(rd_en[0]),
    .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .uart_tx(uart_tx[0]),
    .busy(busy[0]), .done(done[0])
  );

  fb_uart_readback dut1 (
    .clk_o0(clk), .reset_n(rst_n[1]), .start(start[1]),
    .start_addr(start_addr[1]), .len(len[1]), .rd_en(rd_en[1]),
    .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .uart_tx(uart_tx[1]),
    .busy(busy[1]), .done(done[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) tick <= tick + 1;

  function automatic int bd_of(input int d);
    return (d == 0) ? 8 : 208;
  endfunction

  function automatic logic [7:0] ram_rd(input int d, input logic [19:0] a);
    logic [20:0] k;
    k = {1'(d), a};
    return ram.exists(k) ? ram[k] : 8'h00;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rd_en[d] === 1'b1) rd_data[d] <= ram_rd(d, rd_addr[d]);
    end
  end

  function automatic void push_exp(input int d, input logic [7:0] b, input int at);
    frame_t f;
    f.data = b;
    f.at   = at;
    if (d == 0) q0.push_back(f);
    else        q1.push_back(f);
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // UART receiver: mid-bit sampling, aborted whenever its DUT is in reset
  bit         mon_act  [2];
  int         mon_cnt  [2];
  int         mon_at   [2];
  logic [7:0] mon_byte [2];
  bit         mon_ferr [2];
  logic       prev_tx  [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n[d] !== 1'b1) begin
        mon_act[d] = 1'b0;
      end else if (!mon_act[d]) begin
        if (prev_tx[d] === 1'b1 && uart_tx[d] === 1'b0) begin
          mon_act[d]  = 1'b1;
          mon_cnt[d]  = 0;
          mon_at[d]   = tick;
          mon_byte[d] = 8'h00;
          mon_ferr[d] = 1'b0;
        end
      end else begin
        mon_cnt[d] = mon_cnt[d] + 1;
      end
      if (mon_act[d] && (mon_cnt[d] % bd_of(d)) == bd_of(d) / 2) begin
        if (mon_cnt[d] / bd_of(d) == 0) begin
          if (uart_tx[d] !== 1'b0) mon_ferr[d] = 1'b1;
        end else if (mon_cnt[d] / bd_of(d) < 9) begin
          mon_byte[d] = {uart_tx[d], mon_byte[d][7:1]};
        end else begin
          if (uart_tx[d] !== 1'b1) mon_ferr[d] = 1'b1;
          mon_act[d] = 1'b0;
          checks++;
          if (q_size(d) == 0) begin
            errors++;
            $display("FAIL unexpected_frame d%0d: got byte %h, scoreboard empty", d, mon_byte[d]);
          end else begin
            frame_t f;
            f = (d == 0) ? q0.pop_front() : q1.pop_front();
            checks++;
            if (mon_byte[d] !== f.data) begin
              errors++;
              $display("FAIL frame_data d%0d: got %h want %h", d, mon_byte[d], f.data);
            end
            checks++;
            if (mon_at[d] !== f.at) begin
              errors++;
              $display("FAIL frame_start d%0d: got tick %0d want %0d", d, mon_at[d], f.at);
            end
            checks++;
            if (mon_ferr[d]) begin
              errors++;
              $display("FAIL framing d%0d: got bad start/stop want 0/1", d);
            end
          end
        end
      end
      prev_tx[d] = uart_tx[d];
    end
  end

  task automatic run_packet(input int d, input logic [19:0] a, input logic [19:0] n,
                            input bit intrude, input int rst_at);
    int          bd, t0, cyc, k, ndone, busy_bad, done_cyc, window;
    logic [7:0]  s, b;
    logic [19:0] ea;
    bd       = bd_of(d);
    done_cyc = 1 + (int'(n) + 2) * 10 * bd;
    window   = intrude ? 40 : 5;
    @(negedge clk);
    start_addr[d] = a;
    len[d]        = n;
    start[d]      = 1'b1;
    t0            = tick;
    push_exp(d, 8'hA5, t0 + 1);
    s = 8'h00;
    for (int i = 0; i < int'(n); i++) begin
      b = ram_rd(d, a + 20'(i));
      s = s + b;
      push_exp(d, b, t0 + 1 + (i + 1) * 10 * bd);
    end
    push_exp(d, s, t0 + 1 + (int'(n) + 1) * 10 * bd);
    @(negedge clk);
    start[d]      = 1'b0;
    start_addr[d] = ~a;
    len[d]        = n + 20'd7;
    cyc = 1; k = 0; ndone = 0; busy_bad = 0;
    while (cyc <= done_cyc + window) begin
      if (rst_at != 0 && cyc == rst_at) begin
        checks++;
        if (busy[d] !== 1'b1) begin
          errors++;
          $display("FAIL busy_before_reset d%0d: got %b want 1", d, busy[d]);
        end
        #1 rst_n[d] = 1'b0;
        #1;
        checks++;
        if (uart_tx[d] !== 1'b1 || busy[d] !== 1'b0 || rd_en[d] !== 1'b0 ||
            done[d] !== 1'b0 || rd_addr[d] !== 20'h0) begin
          errors++;
          $display("FAIL async_reset d%0d: got tx%b busy%b rd_en%b done%b addr%h want 1 0 0 0 00000",
                   d, uart_tx[d], busy[d], rd_en[d], done[d], rd_addr[d]);
        end
        if (d == 0) q0.delete();
        else        q1.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n[d] = 1'b1;
        return;
      end
      if (intrude) begin
        if (cyc == 50 || cyc == done_cyc) begin
          start[d]      = 1'b1;
          start_addr[d] = 20'h00020;
          len[d]        = 20'd5;
        end else begin
          start[d] = 1'b0;
        end
      end
      if (rd_en[d] === 1'b1) begin
        ea = a + 20'(k);
        checks++;
        if (cyc !== 1 + bd + k * 10 * bd) begin
          errors++;
          $display("FAIL rd_en_cycle d%0d: got cycle %0d want %0d", d, cyc, 1 + bd + k * 10 * bd);
        end
        checks++;
        if (rd_addr[d] !== ea) begin
          errors++;
          $display("FAIL rd_addr d%0d: got %h want %h", d, rd_addr[d], ea);
        end
        k++;
      end
      if ((busy[d] === 1'b1) != (cyc < done_cyc)) busy_bad++;
      if (done[d] === 1'b1) begin
        ndone++;
        checks++;
        if (cyc !== done_cyc) begin
          errors++;
          $display("FAIL done_cycle d%0d: got %0d want %0d", d, cyc, done_cyc);
        end
      end
      @(negedge clk);
      cyc++;
    end
    start[d] = 1'b0;
    checks++;
    if (k !== int'(n)) begin
      errors++;
      $display("FAIL rd_en_count d%0d: got %0d want %0d", d, k, n);
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL done_pulses d%0d: got %0d want 1", d, ndone);
    end
    checks++;
    if (busy_bad !== 0) begin
      errors++;
      $display("FAIL busy_window d%0d: got %0d bad cycles want 0", d, busy_bad);
    end
    checks++;
    if (q_size(d) !== 0) begin
      errors++;
      $display("FAIL frames_missing d%0d: got %0d left want 0", d, q_size(d));
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (uart_tx[d] !== 1'b1 || busy[d] !== 1'b0 || done[d] !== 1'b0 ||
          rd_en[d] !== 1'b0 || rd_addr[d] !== 20'h0) begin
        errors++;
        $display("FAIL reset_values d%0d: got tx%b busy%b done%b rd_en%b addr%h want 1 0 0 0 00000",
                 d, uart_tx[d], busy[d], done[d], rd_en[d], rd_addr[d]);
      end
    end
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (uart_tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got tx%b busy%b want 1 0", uart_tx[0], busy[0]);
    end
  endtask

  task automatic test_basic();
    run_packet(0, 20'h00010, 20'd3, 1'b0, 0);
  endtask

  task automatic test_zero_len();
    run_packet(0, 20'h00040, 20'd0, 1'b0, 0);
  endtask

  task automatic test_addr_wrap();
    run_packet(0, 20'hFFFFF, 20'd2, 1'b0, 0);
  endtask

  task automatic test_start_ignored();
    run_packet(0, 20'h00010, 20'd3, 1'b1, 0);
  endtask

  task automatic test_reset_midpacket();
    run_packet(0, 20'h00010, 20'd3, 1'b0, 123);
    repeat (3) @(negedge clk);
    run_packet(0, 20'h00020, 20'd2, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_packet(0, 20'h00030, 20'd4, 1'b0, 0);
    run_packet(0, 20'h00011, 20'd1, 1'b0, 0);
  endtask

  task automatic test_default_baud();
    run_packet(1, 20'h00100, 20'd1, 1'b0, 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d]      = 1'b0;
      start[d]      = 1'b0;
      start_addr[d] = 20'h0;
      len[d]        = 20'h0;
      rd_data[d]    = 8'h00;
      mon_act[d]    = 1'b0;
      prev_tx[d]    = 1'b1;
    end
    ram[{1'b0, 20'h00010}] = 8'h11;
    ram[{1'b0, 20'h00011}] = 8'h22;
    ram[{1'b0, 20'h00012}] = 8'h33;
    ram[{1'b0, 20'hFFFFF}] = 8'hFF;
    ram[{1'b0, 20'h00000}] = 8'hFF;
    ram[{1'b0, 20'h00020}] = 8'h80;
    ram[{1'b0, 20'h00021}] = 8'h81;
    ram[{1'b0, 20'h00030}] = 8'h01;
    ram[{1'b0, 20'h00031}] = 8'hFE;
    ram[{1'b0, 20'h00032}] = 8'h7F;
    ram[{1'b0, 20'h00033}] = 8'hC3;
    ram[{1'b1, 20'h00100}] = 8'h5A;
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    test_basic();
    test_zero_len();
    test_addr_wrap();
    test_start_ignored();
    test_reset_midpacket();
    test_back_to_back();
    test_default_baud();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_uart_readback.md
# fb_uart_readback

Frame-buffer readback transmitter for the UPduino display design: the outbound counterpart of the UART-to-frame-buffer config path. On a start strobe it reads a byte range from the frame-buffer RAM read port and serializes it on `uart_tx` (8N1) as a framed packet: header, payload, checksum. It runs in the `clk_o0` domain so the host can verify frame-buffer contents after a download.

## Interface
Parameters:
- `BAUD_DIV`, 208: `clk_o0` cycles per UART bit (24 MHz / 115200). Legal range 4..4095.
- `ADDR_W`, 20: RAM address and length width.
- `HDR`, 8'hA5: packet header byte.

Ports:
- `clk_o0`  in  1  block clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request. Sampled only in IDLE.
- `start_addr`  in  ADDR_W  first RAM address. Captured with `start`.
- `len`  in  ADDR_W  payload byte count. Captured with `start`. 0 is legal.
- `rd_en`  out  1  one-cycle RAM read strobe.
- `rd_addr`  out  ADDR_W  RAM read address. Valid while `rd_en`=1.
- `rd_data`  in  8  RAM data. Valid exactly 1 cycle after `rd_en`.
- `uart_tx`  out  1  serial output. Idle high.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at packet end.

## Operation
- Packet on wire: `HDR`, then `len` payload bytes from `start_addr`, `start_addr+1`, …, then `CSUM`.
- `CSUM` = 8-bit sum, mod 256, of the payload bytes only. Header is excluded. For `len`=0, `CSUM` = 8'h00.
- Each byte is sent as: start bit 0, then d0..d7 LSB first, then stop bit 1. Each bit lasts exactly `BAUD_DIV` cycles.
- Frames are back-to-back: the start bit of byte N+1 begins the cycle after the stop bit of byte N ends.
- Address increments modulo 2^ADDR_W. 0xFFFFF is followed by 0x00000.
- Remaining count is a down-counter of ADDR_W bits. Payload ends when it reaches 0.
- FSM states:
  - IDLE: on `start`, latch inputs, clear the sum, load the shift register with `HDR`, go to SHIFT.
  - SHIFT: serialize the current frame. While the header or payload frame N is shifting and remaining > 0, issue the next read: one `rd_en` pulse in the first cycle of that frame's bit 0. Latch `rd_data` and add it to the sum on the next cycle.
  - At end of stop bit:
    - remaining > 0 (prefetched byte pending): load it, decrement remaining, stay in SHIFT.
    - else, if `CSUM` not yet sent: load `CSUM`, stay in SHIFT.
    - else go to DONE.
  - DONE: assert `done` for 1 cycle, drop `busy`, return to IDLE.
- `start` while `busy`=1 is ignored, with no effect on the current packet.
- `start` in the DONE cycle is ignored. It is accepted from IDLE only.
- The RAM read port has no backpressure. Exactly `len` `rd_en` pulses are issued per packet.

## Timing
- Reset values: `uart_tx`=1, `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0. Internal state is IDLE, counters are 0.
- Reset asserted mid-packet forces these values immediately (asynchronous), including `uart_tx` high mid-bit. No partial packet resumes.
- Cycle 0: `start` sampled high. In cycle 1, `busy`=1 and `uart_tx`=0 (header start bit).
- Packet duration: (`len`+2)·10·`BAUD_DIV` cycles from cycle 1. The last stop bit occupies the final `BAUD_DIV` cycles.
- `done`=1 in cycle 1+(`len`+2)·10·`BAUD_DIV`. `busy`=0 in that same cycle.
- First `rd_en` fires in cycle 1+`BAUD_DIV` with `rd_addr`=`start_addr`.
- The k-th `rd_en` (k from 0) fires in cycle 1+`BAUD_DIV`+k·10·`BAUD_DIV`.
- Prefetch slack is ≥ 8·`BAUD_DIV` cycles, so no gap between frames.
- Baud counter: counts 0..`BAUD_DIV`-1, wraps, and advances the bit index on wrap. It is 12 bits wide.

## Test plan
- `BAUD_DIV`=8, `start_addr`=0x00010, `len`=3, RAM[0x10..0x12]=11,22,33 -> wire bytes A5 11 22 33 66. `done` in cycle 401. `rd_en` in cycles 9, 89, 169 with addresses 0x10, 0x11, 0x12.
- `len`=0 -> wire bytes A5 00. No `rd_en` pulses. `done` in cycle 161.
- `start_addr`=0xFFFFF, `len`=2, RAM[0xFFFFF]=FF, RAM[0]=FF -> `rd_addr` 0xFFFFF then 0x00000. Wire bytes A5 FF FF FE (sum wraps mod 256).
- Second `start` (different addr/len) pulsed at cycle 50 of an active packet -> first packet unchanged. No second packet. `busy` stays high until the original `done`.
- `reset_n` low at cycle 123, mid-bit -> `uart_tx`=1, `busy`=0, `rd_en`=0 with no clock edge. After release, a fresh `start` produces a complete correct packet.
- Default `BAUD_DIV`=208, `len`=1, data 0x5A -> each bit measures exactly 208 cycles. Wire bytes A5 5A 5A. Total 6240 cycles.
